// File: rtl/capture_pkg.sv
// Shared types and default sizes for the capture controller.
package capture_pkg;

  localparam int CAP_ADDR_W = 10;
  localparam int CAP_CH     = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PREFILL   = 3'd1,
    ST_WAIT_TRIG = 3'd2,
    ST_POST      = 3'd3,
    ST_DONE      = 3'd4
  } cap_state_e;

endpackage

// File: rtl/capture_trig.sv
// Trigger qualifier: masked OR of the channel edge requests, only on sample
// strobes. An all-zero mask means "trigger on the next strobe".
module capture_trig
  import capture_pkg::*;
#(
  parameter int CH = CAP_CH
) (
  input  logic          i_sample_en,
  input  logic [CH-1:0] i_ch_edge,
  input  logic [CH-1:0] i_trig_mask,
  output logic          o_trig
);

  logic w_mask_empty;
  logic w_any_edge;

  assign w_mask_empty = (i_trig_mask == '0);
  assign w_any_edge   = |(i_ch_edge & i_trig_mask);
  assign o_trig       = i_sample_en & (w_mask_empty | w_any_edge);

endmodule

// File: rtl/capture_ctrl.sv
// Capture controller: sequences sample-memory writes around a trigger event.
// Optional build macro CAPTURE_PRETRIG_EN: fills the buffer with pre-trigger
// history before arming the trigger, then writes circularly until it fires.
module capture_ctrl
  import capture_pkg::*;
#(
  parameter int ADDR_W = CAP_ADDR_W,
  parameter int CH     = CAP_CH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_arm,
  input  logic              i_abort,
  input  logic              i_sample_en,
  input  logic [CH-1:0]     i_ch_edge,
  input  logic [CH-1:0]     i_trig_mask,
  input  logic [ADDR_W-1:0] i_post_count,
  output logic              o_det_reset,
  output logic              o_write_finish,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [ADDR_W-1:0] o_trig_addr,
  output logic              o_busy,
  output logic              o_done
);

  cap_state_e        r_state;
  cap_state_e        w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_trig_addr;
  logic [ADDR_W-1:0] r_post_cnt;
  logic              r_done;
  logic              r_wf;
  logic              w_trig;
  logic              w_we;
  logic              w_fire;
  logic              w_start;

  capture_trig #(.CH(CH)) u_trig (
    .i_sample_en (i_sample_en),
    .i_ch_edge   (i_ch_edge),
    .i_trig_mask (i_trig_mask),
    .o_trig      (w_trig)
  );

  // A new capture may only start from rest; abort always wins over arm.
  assign w_start = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && i_arm && !i_abort;

`ifdef CAPTURE_PRETRIG_EN
  logic [ADDR_W-1:0] r_pre_cnt;
  logic [ADDR_W-1:0] w_pre_len;

  // Leave exactly post_count+1 slots for the trigger sample and its followers.
  assign w_pre_len = {ADDR_W{1'b1}} - i_post_count;
`endif

  // Next-state and write-enable decode.
  always_comb begin
    w_next = r_state;
    w_we   = 1'b0;
    w_fire = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (i_arm) begin
`ifdef CAPTURE_PRETRIG_EN
          w_next = (w_pre_len == '0) ? ST_WAIT_TRIG : ST_PREFILL;
`else
          w_next = ST_WAIT_TRIG;
`endif
        end
      end
`ifdef CAPTURE_PRETRIG_EN
      ST_PREFILL: begin
        w_we = i_sample_en;
        if (i_sample_en && (r_pre_cnt == ADDR_W'(1))) w_next = ST_WAIT_TRIG;
      end
`endif
      ST_WAIT_TRIG: begin
`ifdef CAPTURE_PRETRIG_EN
        w_we = i_sample_en;
`endif
        if (w_trig) begin
          w_we   = 1'b1;
          w_fire = 1'b1;
          w_next = (i_post_count == '0) ? ST_DONE : ST_POST;
        end
      end
      ST_POST: begin
        w_we = i_sample_en;
        if (i_sample_en && (r_post_cnt == ADDR_W'(1))) w_next = ST_DONE;
      end
      default: w_next = ST_IDLE;
    endcase
    if (i_abort) begin
      w_next = ST_IDLE;
      w_we   = 1'b0;
      w_fire = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Address, trigger latch, post counter and completion flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr      <= '0;
      r_trig_addr <= '0;
      r_post_cnt  <= '0;
      r_done      <= 1'b0;
      r_wf        <= 1'b0;
    end else begin
      if (w_start)   r_addr <= '0;
      else if (w_we) r_addr <= r_addr + ADDR_W'(1);
      if (w_fire) begin
        r_trig_addr <= r_addr;
        r_post_cnt  <= i_post_count;
      end else if ((r_state == ST_POST) && w_we) begin
        r_post_cnt  <= r_post_cnt - ADDR_W'(1);
      end
      r_done <= (w_next == ST_DONE);
      r_wf   <= (w_next == ST_DONE) && (r_state != ST_DONE);
    end
  end

`ifdef CAPTURE_PRETRIG_EN
  // Pre-trigger fill counter, loaded when a capture starts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                   r_pre_cnt <= '0;
    else if (w_start)                            r_pre_cnt <= w_pre_len;
    else if ((r_state == ST_PREFILL) && w_we)    r_pre_cnt <= r_pre_cnt - ADDR_W'(1);
  end
`endif

  assign o_mem_we       = w_we;
  assign o_mem_addr     = r_addr;
  assign o_trig_addr    = r_trig_addr;
  assign o_det_reset    = (r_state == ST_IDLE);
  assign o_busy         = (r_state == ST_PREFILL) || (r_state == ST_WAIT_TRIG) ||
                          (r_state == ST_POST);
  assign o_done         = r_done;
  assign o_write_finish = r_wf;

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl (ADDR_W=4, CH=4).
module tb_capture_ctrl;

  localparam int AW = 4;
  localparam int NC = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          arm, abort, sample_en;
  logic [NC-1:0] ch_edge, trig_mask;
  logic [AW-1:0] post_count;
  logic          det_reset, write_finish, mem_we, busy, done;
  logic [AW-1:0] mem_addr, trig_addr;

  int errs   = 0;
  int checks = 0;
  int wf_cnt = 0;
  int wq[$];

  capture_ctrl #(.ADDR_W(AW), .CH(NC)) dut (
    .clk(clk), .reset(reset), .i_arm(arm), .i_abort(abort),
    .i_sample_en(sample_en), .i_ch_edge(ch_edge), .i_trig_mask(trig_mask),
    .i_post_count(post_count), .o_det_reset(det_reset),
    .o_write_finish(write_finish), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_trig_addr(trig_addr), .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, log writes/finish pulses, return just after posedge.
  task automatic tick(input logic a, input logic ab, input logic se, input logic [NC-1:0] e);
    @(negedge clk);
    arm = a; abort = ab; sample_en = se; ch_edge = e;
    #1;
    if (mem_we) wq.push_back(int'(mem_addr));
    if (write_finish) wf_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic chk_writes(input string tag, input int exp[$]);
    chk({tag, "_n"}, wq.size(), exp.size());
    for (int i = 0; i < exp.size() && i < wq.size(); i++)
      chk($sformatf("%s_%0d", tag, i), wq[i], exp[i]);
  endtask

  task automatic start_run(input logic [AW-1:0] pc, input logic [NC-1:0] m);
    wq.delete(); wf_cnt = 0;
    post_count = pc; trig_mask = m;
    tick(1'b1, 1'b0, 1'b0, '0);
  endtask

  initial begin
    reset = 1'b1; arm = 0; abort = 0; sample_en = 0; ch_edge = '0;
    trig_mask = '0; post_count = '0;
    #23;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_det", det_reset, 1);
    chk("rst_addr", mem_addr, 0);
    chk("rst_taddr", trig_addr, 0);
    chk("rst_wf", write_finish, 0);
    chk("rst_we", mem_we, 0);
    @(negedge clk); reset = 1'b0;

`ifdef CAPTURE_PRETRIG_EN
    // 11 prefill writes (edges ignored), 2 circular waits, trigger at 13, post wraps.
    start_run(4'd4, 4'b0001);
    chk("pre_busy", busy, 1);
    for (int i = 0; i < 11; i++) tick(1'b0, 1'b0, 1'b1, 4'b0001);
    chk("pre_taddr", trig_addr, 0);
    chk("pre_addr", mem_addr, 11);
    chk("pre_done", done, 0);
    tick(0, 0, 1, '0); tick(0, 0, 1, '0);
    tick(0, 0, 1, 4'b0001);
    chk("pre_taddr13", trig_addr, 13);
    for (int i = 0; i < 4; i++) tick(0, 0, 1, '0);
    idle(3);
    chk_writes("pre_wr", '{0,1,2,3,4,5,6,7,8,9,10,11,12,13,14,15,0,1});
    chk("pre_done1", done, 1);
    chk("pre_wf", wf_cnt, 1);
`else
    // Trigger on 5th strobe, post_count=3; later post_count change ignored.
    start_run(4'd3, 4'b0001);
    chk("t1_busy", busy, 1);
    chk("t1_det", det_reset, 0);
    tick(0, 0, 1, '0);
    tick(0, 0, 1, '0);
    tick(0, 0, 0, 4'b0001);
    tick(0, 0, 1, 4'b0010);
    tick(0, 0, 1, '0);
    chk("t1_prewr", wq.size(), 0);
    tick(0, 0, 1, 4'b0001);
    post_count = 4'd7;
    tick(0, 0, 1, '0);
    tick(0, 0, 0, '0);
    tick(0, 0, 1, '0);
    chk("t1_notdone", done, 0);
    tick(0, 0, 1, '0);
    idle(4);
    chk_writes("t1_wr", '{0,1,2,3});
    chk("t1_taddr", trig_addr, 0);
    chk("t1_wf", wf_cnt, 1);
    chk("t1_done", done, 1);
    chk("t1_busy0", busy, 0);
    chk("t1_addr", mem_addr, 4);

    // Re-arm from DONE, post_count=0, mask=0: single write then DONE.
    start_run(4'd0, 4'b0000);
    chk("t2_done0", done, 0);
    chk("t2_addr0", mem_addr, 0);
    tick(0, 0, 0, '0);
    chk("t2_busy", busy, 1);
    tick(0, 0, 1, '0);
    chk("t2_done", done, 1);
    idle(2);
    chk_writes("t2_wr", '{0});
    chk("t2_wf", wf_cnt, 1);

    // Abort after 2 of 5 post samples.
    start_run(4'd5, 4'b0001);
    tick(0, 0, 1, 4'b0001);
    tick(0, 0, 1, '0);
    tick(0, 0, 1, '0);
    @(negedge clk);
    abort = 1'b1; sample_en = 1'b1;
    #1;
    chk("t3_we_abort", mem_we, 0);
    @(posedge clk); #1;
    abort = 1'b0; sample_en = 1'b0;
    chk("t3_det", det_reset, 1);
    chk("t3_busy", busy, 0);
    idle(3);
    chk("t3_done", done, 0);
    chk("t3_wf", wf_cnt, 0);
    chk_writes("t3_wr", '{0,1,2});

    // Arm pulse during POST is ignored.
    start_run(4'd2, 4'b0001);
    tick(0, 0, 1, 4'b0001);
    tick(0, 0, 1, '0);
    tick(1, 0, 0, '0);
    chk("t4_busy", busy, 1);
    chk("t4_addr", mem_addr, 2);
    tick(0, 0, 1, '0);
    idle(2);
    chk_writes("t4_wr", '{0,1,2});
    chk("t4_done", done, 1);
    chk("t4_wf", wf_cnt, 1);

    // Asynchronous reset mid-POST: address returns to 0 at once.
    start_run(4'd4, 4'b0001);
    tick(0, 0, 1, 4'b0001);
    tick(0, 0, 1, '0);
    tick(0, 0, 1, '0);
    chk("t5_addr_pre", mem_addr, 3);
    #2; reset = 1'b1; #1;
    chk("t5_addr", mem_addr, 0);
    chk("t5_busy", busy, 0);
    chk("t5_det", det_reset, 1);
    @(negedge clk); reset = 1'b0;

    // Asynchronous reset mid-WAIT_TRIG, with sample strobe held high.
    start_run(4'd3, 4'b0100);
    tick(0, 0, 1, '0);
    sample_en = 1'b1;
    #2; reset = 1'b1; #1;
    chk("t6_busy", busy, 0);
    chk("t6_det", det_reset, 1);
    chk("t6_done", done, 0);
    chk("t6_we", mem_we, 0);
    chk("t6_wf", write_finish, 0);
    @(negedge clk); reset = 1'b0; sample_en = 1'b0;
    idle(2);
    chk("t6_idle_wr", wq.size(), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/capture_ctrl.md
CAPTURE_CTRL -- requirements
Module: capture_ctrl

Interface
REQ-001 Parameter ADDR_W, default 10, sample-memory address width; depth = 2**ADDR_W.
REQ-002 Parameter CH, default 4, number of probe channels.
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high.
REQ-005 arm  input  1  one-cycle pulse; starts a capture.
REQ-006 abort  input  1  level; cancels capture.
REQ-007 sample_en  input  1  sample strobe from the rate divider.
REQ-008 ch_edge  input  CH  per-channel edge requests from the edge detectors.
REQ-009 trig_mask  input  CH  1 = channel may trigger.
REQ-010 post_count  input  ADDR_W  samples to store after the trigger sample.
REQ-011 det_reset  output  1  holds the edge detectors in reset.
REQ-012 write_finish  output  1  one-cycle pulse to the edge detectors at capture end.
REQ-013 mem_we  output  1  sample-memory write enable.
REQ-014 mem_addr  output  ADDR_W  sample-memory write address.
REQ-015 trig_addr  output  ADDR_W  address of the trigger sample.
REQ-016 busy / done  output  1 each  capture active / capture complete (sticky).

Function
REQ-017 FSM states IDLE, PREFILL, WAIT_TRIG, POST, DONE; encoding in the package.
REQ-018 IDLE: det_reset=1, mem_we=0; arm -> PREFILL (PRETRIG build) or WAIT_TRIG (otherwise); mem_addr cleared to 0 on arm.
REQ-019 trig = |(ch_edge & trig_mask), evaluated only in cycles with sample_en=1; trig_mask=0 forces trigger on the first sample_en in WAIT_TRIG.
REQ-020 mem_we = sample_en in PREFILL, WAIT_TRIG (PRETRIG build only) and POST, and on the trigger cycle; combinational from state and sample_en.
REQ-021 mem_addr increments by 1 modulo 2**ADDR_W in the cycle after each mem_we=1; wrap from all-ones to 0 is silent.
REQ-022 Trigger cycle: trig_addr <= current mem_addr, sample written there, post counter loaded with post_count, state -> POST (or DONE if post_count=0).
REQ-023 POST: counter decrements per written sample; write of last sample (counter=1) -> DONE next cycle.
REQ-024 Entry to DONE: write_finish pulses exactly one cycle, done=1, busy=0; done clears on next arm.
REQ-025 busy=1 in PREFILL, WAIT_TRIG, POST.
REQ-026 arm while busy ignored; arm in DONE restarts as from IDLE.
REQ-027 abort (any state) -> IDLE next cycle; mem_we forced 0 in the abort cycle; no write_finish; done cleared.
REQ-028 post_count sampled only at the trigger; later changes ignored.

Reset
REQ-029 reset -> IDLE, mem_addr=0, trig_addr=0, counters=0, done=0, write_finish=0, det_reset=1; effective mid-capture without any further write.

Configuration
REQ-030 With CAPTURE_PRETRIG_EN defined: PREFILL writes 2**ADDR_W-1-post_count samples (trig ignored), then WAIT_TRIG, which keeps writing circularly until trigger.
REQ-031 Without CAPTURE_PRETRIG_EN: PREFILL absent, WAIT_TRIG performs no writes; first write is the trigger sample at address 0.

Structure
REQ-032 Package capture_pkg: state typedef/encoding, default ADDR_W and CH constants.
REQ-033 Sub-module capture_trig (mask-and-reduce of ch_edge, gated by sample_en) is natural; counters and FSM stay in capture_ctrl.

Verification
REQ-034 No PRETRIG, ADDR_W=4, post_count=3, trig_mask=0001, ch_edge[0] on 5th strobe -> writes at addr 0..3, trig_addr=0, write_finish one pulse, done=1.
REQ-035 PRETRIG, ADDR_W=4, post_count=4: 11 prefill writes; ch_edge during prefill ignored; trigger at addr 13 -> post writes 14,15,0,1 (wrap), trig_addr=13.
REQ-036 post_count=0, trigger -> single write, DONE next cycle.
REQ-037 abort asserted in POST after 2 of 5 post samples -> IDLE next cycle, mem_we=0, no write_finish, done=0.
REQ-038 reset asserted asynchronously mid-WAIT_TRIG -> all outputs at reset values immediately; arm pulse during POST ignored.
